// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - serial line and received-word bundle for uart_rx_cfg
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_RX_Serial;
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Busy;

    // master drives the line and consumes received words; slave is the receiver
    modport master (
        output i_RX_Serial,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_Parity_Err,
        input  o_Frame_Err,
        input  o_Busy
    );

    modport slave (
        input  i_RX_Serial,
        output o_RX_DV,
        output o_RX_Byte,
        output o_Parity_Err,
        output o_Frame_Err,
        output o_Busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - UART receiver with configurable width, parity and stop bits
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stops; break-safe.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    uart_rx_cfg_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam bit            HAS_PARITY = (PARITY_MODE != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5,
        S_BREAK  = 3'd6
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_rx_dv;
    logic [DATA_BITS-1:0] r_rx_byte;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_busy;
    logic                 w_data_par;

    assign w_data_par       = ^r_rx_byte;
    assign bus.o_RX_DV      = r_rx_dv;
    assign bus.o_RX_Byte    = r_rx_byte;
    assign bus.o_Parity_Err = r_parity_err;
    assign bus.o_Frame_Err  = r_frame_err;
    assign bus.o_Busy       = r_busy;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.i_RX_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state      <= S_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_par_err    <= 1'b0;
            r_frm_err    <= 1'b0;
            r_rx_dv      <= 1'b0;
            r_rx_byte    <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_clk_cnt == HALF_CNT) begin
                        r_clk_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_DATA;
                            r_bit_idx  <= '0;
                            r_stop_idx <= 1'b0;
                            r_par_err  <= 1'b0;
                            r_frm_err  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                // From here on every sample lands a whole bit after the previous mid-bit
                S_DATA: begin
                    if (r_clk_cnt == LAST_CNT) begin
                        r_clk_cnt            <= '0;
                        r_rx_byte[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == LAST_BIT) begin
                            r_bit_idx <= '0;
                            r_state   <= HAS_PARITY ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (r_clk_cnt == LAST_CNT) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_STOP;
                        if (PARITY_MODE == 1) begin
                            r_par_err <= w_data_par ^ r_rx_s;
                        end else begin
                            r_par_err <= ~(w_data_par ^ r_rx_s);
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_clk_cnt == LAST_CNT) begin
                        r_clk_cnt <= '0;
                        if (!r_rx_s) begin
                            r_frm_err <= 1'b1;
                        end
                        if (r_stop_idx == LAST_STOP) begin
                            r_state      <= S_DONE;
                            r_stop_idx   <= 1'b0;
                            r_rx_dv      <= 1'b1;
                            r_parity_err <= r_par_err;
                            r_frame_err  <= r_frm_err | ~r_rx_s;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_rx_dv      <= 1'b0;
                    r_parity_err <= 1'b0;
                    r_frame_err  <= 1'b0;
                    if (r_frame_err) begin
                        r_state <= S_BREAK;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                // A held-low line must return high before another start can be seen
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_clk_cnt    <= '0;
                    r_rx_dv      <= 1'b0;
                    r_parity_err <= 1'b0;
                    r_frame_err  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule
